// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encoding and divide special-case constants.
package mdu_pkg;

   localparam int MDU_XLEN = 32;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module mdu_divstep
   import mdu_pkg::*;
#(
   parameter int W = MDU_XLEN
) (
   input  logic [W:0]   i_prem,
   input  logic [W-1:0] i_div,
   output logic [W-1:0] o_rem,
   output logic         o_qbit
);

   logic [W:0] w_diff;

   // i_prem < 2*i_div always holds, so a set top bit means the subtract borrowed.
   assign w_diff = i_prem - {1'b0, i_div};
   assign o_qbit = ~w_diff[W];
   assign o_rem  = o_qbit ? w_diff[W-1:0] : i_prem[W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign correction in FIX.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      o_dbg_state
);

   // Handshake: start is accepted on a rising edge only in IDLE or DONE (and
   // not under flush); busy stays high until the result is registered, then
   // done pulses for one cycle and result holds until the next accept.

   mdu_state_e          r_state, w_next_state;
   mdu_op_e             r_op, w_op;
   logic [XLEN-1:0]     r_opnd;
   logic [2*XLEN-1:0]   r_acc;
   logic [4:0]          r_cnt;
   logic                r_neg, r_neg_rem;
   logic [XLEN-1:0]     r_result;

   logic                w_accept, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
   logic [XLEN-1:0]     w_a_mag, w_b_mag;
   logic                w_special;
   logic [XLEN-1:0]     w_special_res;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod_fix;
   logic [XLEN-1:0]     w_div_rem, w_quo_fix, w_rem_fix;
   logic                w_div_qbit;
   logic [XLEN-1:0]     w_fix_res;

   assign w_op     = mdu_op_e'(op);
   assign w_accept = start & ~flush & ((r_state == ST_IDLE) | (r_state == ST_DONE));

   always_comb begin
      w_a_signed = 1'b0;
      w_b_signed = 1'b0;
      case (w_op)
         MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
            w_a_signed = 1'b1;
            w_b_signed = 1'b1;
         end
         MDU_MULHSU: w_a_signed = 1'b1;
         default: ;
      endcase
   end

   assign w_sign_a = w_a_signed & a[XLEN-1];
   assign w_sign_b = w_b_signed & b[XLEN-1];
   assign w_a_mag  = w_sign_a ? (~a + 1'b1) : a;
   assign w_b_mag  = w_sign_b ? (~b + 1'b1) : b;

   // op[1] selects remainder, op[0] selects unsigned within the divide group.
   always_comb begin
      w_special     = 1'b0;
      w_special_res = '0;
      if (w_op[2]) begin
         if (b == '0) begin
            w_special     = 1'b1;
            w_special_res = w_op[1] ? a : DIV_ZERO_Q;
         end else if (!w_op[0] && (a == INT_MIN) && (b == '1)) begin
            w_special     = 1'b1;
            w_special_res = w_op[1] ? '0 : INT_MIN;
         end
      end
   end

   // Multiply: low half holds the multiplier, shifted out as the product grows.
   assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

   // Divide: {remainder, dividend/quotient} shifts left one bit per step.
   mdu_divstep #(.W(XLEN)) u_divstep (
      .i_prem (r_acc[2*XLEN-1:XLEN-1]),
      .i_div  (r_opnd),
      .o_rem  (w_div_rem),
      .o_qbit (w_div_qbit)
   );
   assign w_div_next = {w_div_rem, r_acc[XLEN-2:0], w_div_qbit};

   assign w_prod_fix = r_neg     ? (~r_acc + 1'b1) : r_acc;
   assign w_quo_fix  = r_neg     ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
   assign w_rem_fix  = r_neg_rem ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_res = '0;
      case (r_op)
         MDU_MUL:                        w_fix_res = w_prod_fix[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:              w_fix_res = w_quo_fix;
         MDU_REM, MDU_REMU:              w_fix_res = w_rem_fix;
         default:                        w_fix_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start) w_next_state = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == 5'd31) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: begin
               if (start) w_next_state = w_special ? ST_DONE : ST_CALC;
               else       w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= MDU_MUL;
         r_opnd    <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
      end else if (w_accept) begin
         r_op      <= w_op;
         r_cnt     <= '0;
         r_neg     <= w_sign_a ^ w_sign_b;
         r_neg_rem <= w_sign_a;
         if (w_special) begin
            r_result <= w_special_res;
         end else if (w_op[2]) begin
            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
            r_opnd <= w_b_mag;
         end else begin
            r_acc  <= {{XLEN{1'b0}}, w_b_mag};
            r_opnd <= w_a_mag;
         end
      end else if (!flush && (r_state == ST_CALC)) begin
         r_acc <= r_op[2] ? w_div_next : w_mul_next;
         r_cnt <= r_cnt + 5'd1;
      end else if (!flush && (r_state == ST_FIX)) begin
         r_result <= w_fix_res;
      end
   end

   assign busy        = (r_state == ST_CALC) | (r_state == ST_FIX);
   assign done        = (r_state == ST_DONE);
   assign result      = r_result;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter: expected results and done cycles are
// queued at launch and checked by an independent monitor on each done pulse.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   int          cyc = 0;
   int          t0 = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [31:0] mon_exp;
   int          mon_cyc;

   mdu_iter #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .flush       (flush),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .o_dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 result=0x%08h at cycle %0d, expected no done", result, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_cyc = exp_cyc_q.pop_front();
            check("result", result, mon_exp);
            check("done_cycle", 32'(cyc), 32'(mon_cyc));
         end
      end
   end

   // driver tasks (called at a negedge)
   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      t0    = cyc;
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e, input bit special);
      int lat;
      lat = special ? 1 : 34;
      launch(o, x, y);
      exp_q.push_back(e);
      exp_cyc_q.push_back(t0 + lat);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            a     = $urandom_range(32'hFFFF_FFFF, 0);
            b     = $urandom_range(32'hFFFF_FFFF, 0);
         end
         check({name, "_busy"}, {31'b0, busy}, {31'b0, (!special && (k <= 33))});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // multiply, then back-to-back high-half multiplies launched in DONE
      run_op("mul_7_m3",  MDU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_op("mulhu_m1",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("mulh_m1",   MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      run_op("mulhsu_m1", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

      // signed and unsigned divides
      run_op("div_m7_2",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("rem_m7_2",  MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_100_7", MDU_DIVU, 32'd100,      32'd7, 32'd14,        1'b0);
      run_op("remu_100_7", MDU_REMU, 32'd100,      32'd7, 32'd2,         1'b0);

      // special cases finish in cycle 1 without busy
      run_op("div_by0",   MDU_DIV,  32'd5,       32'd0,         32'hFFFF_FFFF, 1'b1);
      run_op("remu_by0",  MDU_REMU, 32'd5,       32'd0,         32'd5,         1'b1);
      run_op("div_ovf",   MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("rem_ovf",   MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      @(negedge clk);
      check("idle_after_special", 32'(dbg_state), 32'(ST_IDLE));

      // a start during CALC is ignored
      launch(MDU_MUL, 32'h0001_2345, 32'h0000_0100);
      exp_q.push_back(32'h0123_4500);
      exp_cyc_q.push_back(t0 + 34);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      op    = MDU_MULHU;
      a     = 32'd1;
      b     = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (23) @(negedge clk);
      check("ignored_start_busy34", {31'b0, busy}, 32'd0);

      // flush a divide mid-flight (launched in the DONE cycle above)
      launch(MDU_DIV, 32'd1000, 32'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("flush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_result", result, 32'h0123_4500);
      repeat (40) @(negedge clk);
      check("flush_result_held", result, 32'h0123_4500);

      // asynchronous reset mid-divide
      launch(MDU_DIVU, 32'd1000, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("prereset_busy", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", {31'b0, busy}, 32'd0);
      check("async_rst_done", {31'b0, done}, 32'd0);
      check("async_rst_result", result, 32'd0);
      check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("mul_after_rst", MDU_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
